// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encodings and frame constants for the imem loader
//
// Purpose: state encoding for the loader FSM, frame layout constants and the
// 8-bit wrap-around checksum helper. Imported by imem_loader and imem_word_packer.
// Ports: none (package).

package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_HDR0  = 3'd0,
      S_HDR1  = 3'd1,
      S_DATA  = 3'd2,
      S_CSUM  = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;

   function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs four bytes MSB-first into one 32-bit imem word
//
// Purpose: shift/assembly register with a byte index. The cycle after the
// fourth byte is accepted, o_word_valid pulses for one cycle with the word.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_clear         synchronous clear of the byte index and partial word
//   i_byte_valid    a byte of the current word is accepted this cycle
//   i_byte          byte value
//   o_byte_idx      position (0..3) of the next byte within the word
//   o_word_valid    one-cycle pulse, o_word holds a complete word
//   o_word          last assembled word (held until the next one)

import imem_loader_pkg::*;

module imem_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic [1:0]  o_byte_idx,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  r_idx;
   logic [23:0] r_shift;
   logic        r_word_valid;
   logic [31:0] r_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx        <= 2'd0;
         r_shift      <= 24'd0;
         r_word_valid <= 1'b0;
         r_word       <= 32'd0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_clear) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
         end else if (i_byte_valid) begin
            if (r_idx == IDX_LAST) begin
               r_word       <= {r_shift, i_byte};
               r_word_valid <= 1'b1;
            end
            r_shift <= {r_shift[15:0], i_byte};
            r_idx   <= r_idx + 2'd1;
         end
      end
   end

   assign o_byte_idx   = r_idx;
   assign o_word_valid = r_word_valid;
   assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing imem and gating cpu reset
//
// Purpose: receives a frame {N[15:8], N[7:0], N x 4 data bytes, checksum},
// writes the N words to imem from address 0 and releases cpu_rst only after
// the 8-bit wrap-around checksum of header+data matches.
// Optional feature macro LOADER_TIMEOUT_EN: inter-byte timeout of TIMEOUT_CYC
// cycles in HDR1/DATA/CSUM leads to ERROR.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   reload        one-cycle pulse, restart the load sequence
//   rx_valid      source presents a byte on rx_data
//   rx_data       byte value
//   rx_ready      loader accepts the byte this cycle
//   mem_addr      imem word address
//   mem_in        imem write data
//   mem_we        imem write enable, one-cycle pulse
//   cpu_rst       processor reset, high while not DONE
//   done          program loaded and verified
//   err           load failed

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reload,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_in,
   output logic                  mem_we,
   output logic                  cpu_rst,
   output logic                  done,
   output logic                  err
);

   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;
   localparam logic [1:0]  IDX_LAST  = 2'(BYTES_PER_WORD - 1);

   loader_state_t r_state;
   loader_state_t w_next_state;

   logic [15:0]           r_count;
   logic [7:0]            r_sum;
   logic [ADDR_WIDTH:0]   r_word_idx;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_done;
   logic                  r_err;
   logic                  r_cpu_rst;

   logic        w_active;
   logic        w_accept;
   logic        w_data_accept;
   logic [15:0] w_n;
   logic [1:0]  w_byte_idx;
   logic        w_word_end;
   logic        w_last_word;
   logic        w_word_valid;
   logic [31:0] w_word;
   logic        w_timeout;

   assign w_active = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                     (r_state == S_DATA) || (r_state == S_CSUM);
   assign rx_ready      = w_active && !reload;
   assign w_accept      = rx_valid && rx_ready;
   assign w_data_accept = w_accept && (r_state == S_DATA);

   // Full word count as it will be once the low header byte is stored.
   assign w_n = {r_count[15:8], rx_data};

   assign w_word_end  = w_data_accept && (w_byte_idx == IDX_LAST);
   assign w_last_word = ((17'(r_word_idx) + 17'd1) == {1'b0, r_count});

   imem_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (reload),
      .i_byte_valid (w_data_accept),
      .i_byte       (rx_data),
      .o_byte_idx   (w_byte_idx),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

`ifdef LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_timed;

   // HDR0 is the idle wait for a new frame, so it never times out.
   assign w_timed   = (r_state == S_HDR1) || (r_state == S_DATA) || (r_state == S_CSUM);
   assign w_timeout = w_timed && !w_accept && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (reload || w_accept || !w_timed) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   logic w_unused_tmo;
   assign w_timeout    = 1'b0;
   assign w_unused_tmo = (TIMEOUT_CYC != 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_HDR0;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_HDR0: begin
            if (w_accept) begin
               w_next_state = S_HDR1;
            end
         end
         S_HDR1: begin
            if (w_accept) begin
               if ({1'b0, w_n} > MAX_WORDS) begin
                  w_next_state = S_ERROR;
               end else if (w_n == 16'd0) begin
                  w_next_state = S_CSUM;
               end else begin
                  w_next_state = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_word_end && w_last_word) begin
               w_next_state = S_CSUM;
            end
         end
         S_CSUM: begin
            if (w_accept) begin
               w_next_state = (rx_data == r_sum) ? S_DONE : S_ERROR;
            end
         end
         S_DONE:  w_next_state = S_DONE;
         S_ERROR: w_next_state = S_ERROR;
         default: w_next_state = S_ERROR;
      endcase
      if (w_timeout) begin
         w_next_state = S_ERROR;
      end
      if (reload) begin
         w_next_state = S_HDR0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count    <= 16'd0;
         r_sum      <= 8'd0;
         r_word_idx <= '0;
         r_mem_addr <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_cpu_rst  <= 1'b1;
      end else begin
         r_done    <= (w_next_state == S_DONE);
         r_err     <= (w_next_state == S_ERROR);
         r_cpu_rst <= (w_next_state != S_DONE);
         if (reload) begin
            r_count    <= 16'd0;
            r_sum      <= 8'd0;
            r_word_idx <= '0;
         end else if (w_accept) begin
            case (r_state)
               S_HDR0: begin
                  r_count[15:8] <= rx_data;
                  r_sum         <= rx_data;
               end
               S_HDR1: begin
                  r_count[7:0] <= rx_data;
                  r_sum        <= sum8(r_sum, rx_data);
                  r_word_idx   <= '0;
               end
               S_DATA: begin
                  r_sum <= sum8(r_sum, rx_data);
                  // Address is latched with the final byte so it lines up
                  // with the packer's word_valid pulse on the next cycle.
                  if (w_word_end) begin
                     r_mem_addr <= r_word_idx[ADDR_WIDTH-1:0];
                     r_word_idx <= r_word_idx + 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign mem_addr = r_mem_addr;
   assign mem_in   = w_word;
   // A write still pending when reload arrives is discarded.
   assign mem_we   = w_word_valid && !reload;
   assign cpu_rst  = r_cpu_rst;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
//
// Directed frames from the test plan followed by randomized frames, each
// compared against a frame-level reference model of the expected imem writes
// and final done/err status.

module tb_imem_loader;

   localparam int AW  = 12;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          reload;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_in;
   logic          mem_we;
   logic          cpu_rst;
   logic          done;
   logic          err;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] got_addr[$];
   logic [31:0]   got_data[$];

   imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYC(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .reload   (reload),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .mem_addr (mem_addr),
      .mem_in   (mem_in),
      .mem_we   (mem_we),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         got_addr.push_back(mem_addr);
         got_data.push_back(mem_in);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output bit acc);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      acc = (rx_ready === 1'b1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
      bit acc;
      for (int i = 0; i < bytes.size(); i++) begin
         send_byte(bytes[i], acc);
         if (!acc) break;
         if (max_gap > 0) idle($urandom_range(max_gap, 0));
      end
      idle(3);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      got_addr.delete();
      got_data.delete();
   endtask

   // Frame-level reference: parse the byte list by the frame rules.
   task automatic model(input logic [7:0] bytes[$], output logic [31:0] wdat[$],
                        output bit exp_done, output bit exp_err);
      int n;
      logic [7:0] s;
      wdat     = {};
      exp_done = 1'b0;
      exp_err  = 1'b0;
      n = int'(bytes[0]) * 256 + int'(bytes[1]);
      if (n > (1 << AW)) begin
         exp_err = 1'b1;
         return;
      end
      s = bytes[0] + bytes[1];
      for (int w = 0; w < n; w++) begin
         wdat.push_back({bytes[2+4*w], bytes[3+4*w], bytes[4+4*w], bytes[5+4*w]});
         for (int k = 0; k < 4; k++) s = s + bytes[2+4*w+k];
      end
      if (bytes[2+4*n] == s) exp_done = 1'b1;
      else                   exp_err  = 1'b1;
   endtask

   task automatic verify(input string tag, input logic [7:0] bytes[$]);
      logic [31:0] wdat[$];
      bit ed, ee;
      model(bytes, wdat, ed, ee);
      @(negedge clk);
      check($sformatf("%s.nwrites", tag), 64'(got_data.size()), 64'(wdat.size()));
      for (int i = 0; i < wdat.size() && i < got_data.size(); i++) begin
         check($sformatf("%s.addr%0d", tag, i), 64'(got_addr[i]), 64'(i));
         check($sformatf("%s.data%0d", tag, i), 64'(got_data[i]), 64'(wdat[i]));
      end
      check($sformatf("%s.done", tag), 64'(done), 64'(ed));
      check($sformatf("%s.err", tag), 64'(err), 64'(ee));
      check($sformatf("%s.cpu_rst", tag), 64'(cpu_rst), 64'(!ed));
      check($sformatf("%s.rx_ready", tag), 64'(rx_ready), 64'(!(ed || ee)));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] fr[$];
      logic [7:0] part[$];
      bit acc;
      int n;
      logic [7:0] s;

      rst      = 1'b1;
      reload   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(2);
      check("rst.rx_ready", 64'(rx_ready), 64'd1);
      check("rst.cpu_rst",  64'(cpu_rst),  64'd1);
      check("rst.done",     64'(done),     64'd0);
      check("rst.err",      64'(err),      64'd0);
      check("rst.mem_we",   64'(mem_we),   64'd0);
      check("rst.mem_addr", 64'(mem_addr), 64'd0);
      check("rst.mem_in",   64'(mem_in),   64'd0);
      rst = 1'b0;
      idle(1);

      fr = '{8'h00, 8'h01, 8'h24, 8'h01, 8'h00, 8'h05, 8'h2B};
      send_frame(fr, 0);
      check("single.word", 64'(got_data.size() > 0 ? got_data[0] : 32'h0), 64'h24010005);
      verify("single", fr);

      do_reload();
      fr = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'hCE};
      send_frame(fr, 3);
      verify("gaps", fr);

      do_reload();
      fr = '{8'h00, 8'h01, 8'h24, 8'h01, 8'h00, 8'h05, 8'h2C};
      send_frame(fr, 0);
      verify("badsum", fr);

      do_reload();
      fr = '{8'h10, 8'h01, 8'h00};
      send_frame(fr, 0);
      verify("oversize", fr);

      do_reload();
      fr = '{8'h00, 8'h00, 8'h00};
      send_frame(fr, 0);
      verify("empty", fr);

      // Reload mid-DATA, with a byte offered during the reload cycle.
      do_reload();
      part = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h11, 8'h11};
      for (int i = 0; i < part.size(); i++) send_byte(part[i], acc);
      reload   = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h22;
      @(negedge clk);
      check("reload.rx_ready", 64'(rx_ready), 64'd0);
      check("reload.mem_we",   64'(mem_we),   64'd0);
      @(posedge clk);
      #1;
      reload   = 1'b0;
      rx_valid = 1'b0;
      got_addr.delete();
      got_data.delete();
      @(negedge clk);
      check("reload.cpu_rst", 64'(cpu_rst), 64'd1);
      check("reload.ready",   64'(rx_ready), 64'd1);
      @(posedge clk);
      #1;
      fr = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'hCE};
      send_frame(fr, 0);
      verify("resend", fr);

      // Async reset mid-frame, checked before any clock edge.
      do_reload();
      part = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < part.size(); i++) send_byte(part[i], acc);
      rst = 1'b1;
      #1;
      check("arst.cpu_rst",  64'(cpu_rst),  64'd1);
      check("arst.done",     64'(done),     64'd0);
      check("arst.err",      64'(err),      64'd0);
      check("arst.mem_we",   64'(mem_we),   64'd0);
      check("arst.mem_addr", 64'(mem_addr), 64'd0);
      check("arst.mem_in",   64'(mem_in),   64'd0);
      check("arst.rx_ready", 64'(rx_ready), 64'd1);
      idle(1);
      rst = 1'b0;
      idle(1);
      got_addr.delete();
      got_data.delete();

      for (int it = 0; it < 20; it++) begin
         do_reload();
         n = $urandom_range(6, 0);
         fr = {};
         fr.push_back(8'h00);
         fr.push_back(8'(n));
         s = 8'(n);
         for (int k = 0; k < 4 * n; k++) begin
            fr.push_back(8'($urandom));
            s = s + fr[fr.size()-1];
         end
         if ($urandom_range(3, 0) == 0) s = s ^ 8'(1 << $urandom_range(7, 0));
         fr.push_back(s);
         send_frame(fr, $urandom_range(2, 0));
         verify($sformatf("rand%0d", it), fr);
      end

`ifdef LOADER_TIMEOUT_EN
      do_reload();
      send_byte(8'h00, acc);
      send_byte(8'h01, acc);
      idle(TMO - 2);
      @(negedge clk);
      check("tmo.before", 64'(err), 64'd0);
      @(posedge clk);
      #1;
      idle(2);
      @(negedge clk);
      check("tmo.err", 64'(err), 64'd1);
      @(posedge clk);
      #1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
